// File: rtl/mem_copy_engine.sv
`default_nettype none
// ============================================================================
// Module      : mem_copy_engine
// Description : Word-copy initiator for a single-port data memory (read then
//               write per word). Optional fill mode via MEM_COPY_FILL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_copy_engine #(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [LEN_WIDTH-1:0] length,
`ifdef MEM_COPY_FILL_EN
  input  logic                 fill,
  input  logic [31:0]          fill_value,
`endif
  input  logic [31:0]          mem_read_data,
  output logic [31:0]          mem_address,
  output logic [31:0]          mem_write_data,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] c_WORD_STEP  = 32'd4;
  localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;

  state_t               r_state;
  state_t               w_next;
  logic [31:0]          r_src;
  logic [31:0]          r_dst;
  logic [31:0]          r_data;
  logic [LEN_WIDTH-1:0] r_remaining;
  logic                 w_fill_start;
  logic                 w_fill;
  logic [31:0]          w_wdata;

`ifdef MEM_COPY_FILL_EN
  logic        r_fill;
  logic [31:0] r_fill_value;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fill       <= 1'b0;
      r_fill_value <= 32'd0;
    end else if (r_state == S_IDLE && start) begin
      r_fill       <= fill;
      r_fill_value <= fill_value;
    end
  end

  assign w_fill_start = fill;
  assign w_fill       = r_fill;
  assign w_wdata      = r_fill ? r_fill_value : r_data;
`else
  assign w_fill_start = 1'b0;
  assign w_fill       = 1'b0;
  assign w_wdata      = r_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (length == '0)      w_next = S_DONE;
          else if (w_fill_start) w_next = S_WRITE;
          else                   w_next = S_READ;
        end
      end
      S_READ:  w_next = S_WRITE;
      S_WRITE: begin
        // remaining still holds the pre-decrement count here
        if (r_remaining == LEN_WIDTH'(1)) w_next = S_DONE;
        else if (w_fill)                  w_next = S_WRITE;
        else                              w_next = S_READ;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_src       <= 32'd0;
      r_dst       <= 32'd0;
      r_data      <= 32'd0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src       <= src_addr & c_ALIGN_MASK;
            r_dst       <= dst_addr & c_ALIGN_MASK;
            r_remaining <= length;
          end
        end
        S_READ: begin
          r_data <= mem_read_data;
          r_src  <= r_src + c_WORD_STEP;
        end
        S_WRITE: begin
          r_dst       <= r_dst + c_WORD_STEP;
          r_remaining <= r_remaining - LEN_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = 32'd0;
    mem_write_data = 32'd0;
    case (r_state)
      S_READ: begin
        mem_read    = 1'b1;
        mem_address = r_src;
      end
      S_WRITE: begin
        mem_write      = 1'b1;
        mem_address    = r_dst;
        mem_write_data = w_wdata;
      end
      default: ;
    endcase
  end

  assign busy = (r_state == S_READ) || (r_state == S_WRITE);
  assign done = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: doc/mem_copy_engine.md
# mem_copy_engine

Word-copy initiator for the single-port data memory: it drives the memory's address, write-data and read/write strobes to move a block of 32-bit words from a source region to a destination region. It sits beside the pipeline's MEM stage and arbitrates at system level through `busy`. The memory read is combinational and the write is clocked. Each word therefore costs one read cycle and one write cycle.

## Interface
Parameters:
- `LEN_WIDTH`, default 16: width of the word-count input.

Ports:
- `clk`  in  1: system clock, all state on posedge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: launch request, sampled only in IDLE.
- `src_addr`  in  32: source byte address, bits [1:0] ignored.
- `dst_addr`  in  32: destination byte address, bits [1:0] ignored.
- `length`  in  LEN_WIDTH: number of words to copy.
- `mem_read_data`  in  32: memory `Read_data`, combinational.
- `mem_address`  out  32: memory `Address`, bits [1:0] always 0.
- `mem_write_data`  out  32: memory `Write_data`.
- `mem_read`  out  1: memory `MemRead`.
- `mem_write`  out  1: memory `MemWrite`.
- `busy`  out  1: high in READ and WRITE.
- `done`  out  1: one-cycle completion pulse.
- `fill`  in  1: fill-mode select, present only with `MEM_COPY_FILL_EN`.
- `fill_value`  in  32: fill word, present only with `MEM_COPY_FILL_EN`.

## Operation
- State machine states: IDLE, READ, WRITE, DONE.
- **IDLE:**
  - `start`=1 latches `src_addr`/`dst_addr` with bits [1:0] cleared.
  - It also latches `length` into `remaining`.
  - If `length`=0, go to DONE. Otherwise go to READ.
- **READ:**
  - `mem_read`=1 and `mem_address`=src pointer.
  - At the clock edge, capture `mem_read_data` into a data register, add 4 to the src pointer, then go to WRITE.
- **WRITE:**
  - `mem_write`=1, `mem_address`=dst pointer, `mem_write_data`=data register.
  - At the clock edge, add 4 to the dst pointer and decrement `remaining`.
  - If `remaining` was 1, go to DONE. Otherwise go to READ.
- **DONE:**
  - `done`=1 for exactly one cycle, then go to IDLE.
- `start` is ignored outside IDLE, including in DONE.
- Inputs are not re-sampled during a transfer.
- Outputs are registered-state decodes.
- `mem_read` and `mem_write` are never high in the same cycle.
- `mem_address` and `mem_write_data` are 0 whenever the corresponding strobe is low.
- Pointers are 32-bit modulo: 0xFFFFFFFC+4 wraps to 0x00000000 with no error.
- Overlapping regions copy in ascending address order. A forward overlap (dst > src, within length) therefore propagates earlier words, and no memmove semantics are provided.
- Length is unsigned. The maximum `2^LEN_WIDTH-1` is legal.

## Timing
- **Reset:**
  - State is IDLE.
  - All outputs are 0: `mem_address`, `mem_write_data`, `mem_read`, `mem_write`, `busy`, `done`.
  - Pointers, data register and `remaining` are cleared.
- **Reset mid-transfer:** at the next edge the block is in IDLE. No further `mem_write` is issued, and any partially copied words remain in memory.
- **Latency:** with `start` accepted at edge T0:
  - The first READ cycle follows T0.
  - `done` is high in cycle 2N+1 after T0.
- **N=0:** `done` is high in the cycle immediately after T0, with no memory strobes.
- **Back-to-back:** the earliest next accepted `start` is the cycle after `done`, when the block is in IDLE.
- **Throughput:** 2 cycles/word in copy mode.

## Configuration
- Macro: `MEM_COPY_FILL_EN`.
- **Defined:**
  - Ports `fill` and `fill_value` exist.
  - `fill` and `fill_value` are latched with `start`.
  - If the latched `fill`=1, the READ state is never entered. WRITE repeats every cycle with `mem_write_data`=latched `fill_value`, and `mem_read` stays 0.
  - `done` follows N+1 cycles after T0.
- **Undefined:** the ports are absent and the block is copy-only, behaving exactly as if `fill`=0.

## Test plan
- **Basic copy:** memory words at 0x10..0x1C = A,B,C,D; start with src=0x10, dst=0x80, length=4.
  - Memory 0x80..0x8C = A,B,C,D.
  - Exactly 4 `mem_read` and 4 `mem_write` cycles, alternating.
  - `done` in cycle 9.
  - Source words unchanged.
- **Zero length:** start with length=0.
  - `done` in cycle 1.
  - `mem_read`/`mem_write` never asserted.
  - `busy` never asserted.
- **Wrap and misalignment:** start with src=0xFFFFFFFD, dst=0x00000043, length=2.
  - Read addresses 0xFFFFFFFC then 0x00000000.
  - Write addresses 0x40 then 0x44.
- **Ignored start and reset abort:**
  - Pulse `start` with new addresses during WRITE of word 2 of 8: the transfer is unaffected.
  - Assert `reset` in READ of word 5: the next cycle is IDLE with all outputs 0, exactly 4 words written, and destination words 5..8 untouched.
- **Fill mode (`MEM_COPY_FILL_EN`):** fill=1, fill_value=0xDEADBEEF, dst=0x100, length=3.
  - Memory 0x100..0x108 = 0xDEADBEEF.
  - Zero read cycles.
  - `done` in cycle 4.
- **Overlap:** words at 0x20..0x2C = 1,2,3,4; start with src=0x20, dst=0x24, length=3.
  - Memory 0x20..0x2C = 1,1,1,1, confirming ascending-order semantics.
